// File: rtl/sensor_debounce.sv
// Door-sensor conditioning: two-flop synchronizer plus a four-state
// debounce FSM per channel, clean levels, one-cycle edge pulses and a
// saturating count of rejected glitches shared by both channels.
//
// Handshake note: there is no valid/ready traffic here. Outputs are plain
// registered levels. rise/fall pulses are high for exactly one cycle, the
// cycle after the edge that accepts a new level.

module sensor_debounce_chan #(
  parameter int N_STABLE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_i,
  output logic       out_o,
  output logic       rise_o,
  output logic       fall_o,
  output logic       glitch_o,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    ST0 = 2'd0,
    P1  = 2'd1,
    ST1 = 2'd2,
    P0  = 2'd3
  } state_t;

  localparam logic [7:0] LAST = 8'(N_STABLE - 1);

  logic   sync1_q, sync2_q;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic   out_q, out_d;
  logic   rise_q, rise_d;
  logic   fall_q, fall_d;

  // Two-flop synchronizer; sync2_q is the only value the FSM looks at.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // State, stability counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST0;
      cnt_q   <= 8'd0;
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Next-state logic: a pending change completes after LAST+1 matching
  // samples; an opposing sample aborts it and flags one glitch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    glitch_o = 1'b0;
    case (state_q)
      ST0: begin
        if (sync2_q) begin
          state_d = P1;
          cnt_d   = 8'd1;
        end
      end
      P1: begin
        if (!sync2_q) begin
          state_d  = ST0;
          cnt_d    = 8'd0;
          glitch_o = 1'b1;
        end else if (cnt_q == LAST) begin
          state_d = ST1;
          out_d   = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST1: begin
        if (!sync2_q) begin
          state_d = P0;
          cnt_d   = 8'd1;
        end
      end
      P0: begin
        if (sync2_q) begin
          state_d  = ST1;
          cnt_d    = 8'd0;
          glitch_o = 1'b1;
        end else if (cnt_q == LAST) begin
          state_d = ST0;
          out_d   = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST0;
        cnt_d   = 8'd0;
      end
    endcase
  end

  assign out_o   = out_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign state_o = state_q;

endmodule

module sensor_debounce #(
  parameter int N_STABLE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sf_raw,
  input  logic       sm_raw,
  output logic       sf,
  output logic       sm,
  output logic       sf_rise,
  output logic       sf_fall,
  output logic       sm_rise,
  output logic       sm_fall,
  output logic [7:0] glitch_cnt,
  output logic [3:0] dbg_state_o
);

  logic       sf_glitch, sm_glitch;
  logic [1:0] sf_state, sm_state;
  logic [7:0] glitch_cnt_q, glitch_cnt_d;
  logic [8:0] glitch_sum;

  sensor_debounce_chan #(.N_STABLE(N_STABLE)) u_sf (
    .clk      (clk),
    .reset    (reset),
    .raw_i    (sf_raw),
    .out_o    (sf),
    .rise_o   (sf_rise),
    .fall_o   (sf_fall),
    .glitch_o (sf_glitch),
    .state_o  (sf_state)
  );

  sensor_debounce_chan #(.N_STABLE(N_STABLE)) u_sm (
    .clk      (clk),
    .reset    (reset),
    .raw_i    (sm_raw),
    .out_o    (sm),
    .rise_o   (sm_rise),
    .fall_o   (sm_fall),
    .glitch_o (sm_glitch),
    .state_o  (sm_state)
  );

  // Add 0..2 glitch events per cycle, clamping at 255 instead of wrapping.
  always_comb begin
    glitch_sum = {1'b0, glitch_cnt_q} + 9'(sf_glitch) + 9'(sm_glitch);
    if (glitch_sum > 9'd255) glitch_cnt_d = 8'hFF;
    else                     glitch_cnt_d = glitch_sum[7:0];
  end

  // Diagnostic glitch counter, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) glitch_cnt_q <= 8'd0;
    else       glitch_cnt_q <= glitch_cnt_d;
  end

  assign glitch_cnt  = glitch_cnt_q;
  assign dbg_state_o = {sm_state, sf_state};

endmodule

// File: tb/tb_sensor_debounce.sv
// Directed bench for sensor_debounce: stimulus pushes expected pulse events
// (cycle, pulses, levels, glitch count) into exp_q; a negedge monitor pops
// and compares whenever any pulse output is high.

module tb_sensor_debounce;

  localparam int N = 4;
  localparam int W = 30;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       sf_raw, sm_raw;
  logic       sf, sm, sf_rise, sf_fall, sm_rise, sm_fall;
  logic [7:0] glitch_cnt;
  logic [3:0] dbg_state;
  logic [15:0] cyc = 16'd0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 16'd1;

  sensor_debounce #(.N_STABLE(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .sf_raw      (sf_raw),
    .sm_raw      (sm_raw),
    .sf          (sf),
    .sm          (sm),
    .sf_rise     (sf_rise),
    .sf_fall     (sf_fall),
    .sm_rise     (sm_rise),
    .sm_fall     (sm_fall),
    .glitch_cnt  (glitch_cnt),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [7:0]   exp_gc;
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] obs();
    return 32'({sf, sm, sf_rise, sf_fall, sm_rise, sm_fall, glitch_cnt});
  endfunction

  // Expected event: cycle index, {sf_rise,sf_fall,sm_rise,sm_fall}, levels, count.
  function automatic logic [W-1:0] ev(input logic [15:0] at, input logic [3:0] p,
                                      input logic lsf, input logic lsm);
    return {at, p, lsf, lsm, exp_gc};
  endfunction

  function automatic logic [31:0] lvl(input logic lsf, input logic lsm, input logic [7:0] gc);
    return 32'({lsf, lsm, 4'b0000, gc});
  endfunction

  // ---------------- monitor ----------------
  logic [W-1:0] mon_e;
  always @(negedge clk) begin
    if (sf_rise | sf_fall | sm_rise | sm_fall) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got %0h at cycle %0d expected no pulse",
                 {sf_rise, sf_fall, sm_rise, sm_fall}, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_event",
              32'({cyc, sf_rise, sf_fall, sm_rise, sm_fall, sf, sm, glitch_cnt}),
              32'(mon_e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic gc_add(input int k);
    int t;
    t = int'(exp_gc) + k;
    exp_gc = (t > 255) ? 8'd255 : 8'(t);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    sf_raw = 1'b0;
    sm_raw = 1'b0;
    step(2);
    reset  = 1'b0;
    exp_gc = 8'd0;
  endtask

  // Drive `level` on the selected channels for len samples, then restore.
  task automatic glitch(input logic on_sf, input logic on_sm, input logic level, input int len);
    if (on_sf) sf_raw = level;
    if (on_sm) sm_raw = level;
    step(len);
    if (on_sf) sf_raw = ~level;
    if (on_sm) sm_raw = ~level;
    step(6);
    gc_add(int'(on_sf) + int'(on_sm));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset  = 1'b1;
    sf_raw = 1'b0;
    sm_raw = 1'b0;
    exp_gc = 8'd0;
    @(negedge clk);
    do_reset();
    check("reset_outputs", obs(), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    step(20);
    check("idle_20", obs(), 32'd0);

    // floor sensor rise: visible N+2 negedges after the drive
    exp_q.push_back(ev(cyc + 16'(N + 2), 4'b1000, 1'b1, 1'b0));
    sf_raw = 1'b1;
    step(N + 4);
    check("sf_high", obs(), lvl(1'b1, 1'b0, exp_gc));

    // 3-sample low excursion while high is rejected
    glitch(1'b1, 1'b0, 1'b0, 3);
    check("sf_low_glitch", obs(), lvl(1'b1, 1'b0, exp_gc));

    // floor sensor fall
    exp_q.push_back(ev(cyc + 16'(N + 2), 4'b0100, 1'b0, 1'b0));
    sf_raw = 1'b0;
    step(N + 4);
    check("sf_low", obs(), lvl(1'b0, 1'b0, exp_gc));

    // exactly N samples high on sm: accepted, then falls
    exp_q.push_back(ev(cyc + 16'(N + 2), 4'b0010, 1'b0, 1'b1));
    exp_q.push_back(ev(cyc + 16'(2 * N + 2), 4'b0001, 1'b0, 1'b0));
    sm_raw = 1'b1;
    step(N);
    sm_raw = 1'b0;
    step(N + 6);
    check("sm_min_width", obs(), lvl(1'b0, 1'b0, exp_gc));

    // N-1 samples on sm: one glitch, no level change
    glitch(1'b0, 1'b1, 1'b1, N - 1);
    check("sm_glitch_one", obs(), lvl(1'b0, 1'b0, 8'd2));
    for (int i = 0; i < 299; i++) glitch(1'b0, 1'b1, 1'b1, N - 1);
    check("gc_saturate", obs(), lvl(1'b0, 1'b0, 8'd255));

    // simultaneous rise and fall on both channels
    do_reset();
    check("reset_clears_gc", obs(), 32'd0);
    exp_q.push_back(ev(cyc + 16'(N + 2), 4'b1010, 1'b1, 1'b1));
    sf_raw = 1'b1;
    sm_raw = 1'b1;
    step(N + 4);
    check("both_high", obs(), lvl(1'b1, 1'b1, exp_gc));
    exp_q.push_back(ev(cyc + 16'(N + 2), 4'b0101, 1'b0, 1'b0));
    sf_raw = 1'b0;
    sm_raw = 1'b0;
    step(N + 4);
    check("both_low", obs(), lvl(1'b0, 1'b0, exp_gc));

    // back-to-back: new low sampled at the edge that accepts the high
    exp_q.push_back(ev(cyc + 16'(N + 2), 4'b1000, 1'b1, 1'b0));
    exp_q.push_back(ev(cyc + 16'(2 * N + 3), 4'b0100, 1'b0, 1'b0));
    sf_raw = 1'b1;
    step(N + 1);
    sf_raw = 1'b0;
    step(N + 6);
    check("back_to_back", obs(), lvl(1'b0, 1'b0, exp_gc));

    // simultaneous 2-sample glitches: +2 per event, 254 + 2 -> 255
    do_reset();
    glitch(1'b1, 1'b1, 1'b1, 2);
    check("double_glitch", obs(), lvl(1'b0, 1'b0, 8'd2));
    for (int i = 0; i < 126; i++) glitch(1'b1, 1'b1, 1'b1, 2);
    check("gc_254", obs(), lvl(1'b0, 1'b0, 8'd254));
    glitch(1'b1, 1'b1, 1'b1, 2);
    check("gc_254_plus_2", obs(), lvl(1'b0, 1'b0, 8'd255));

    // reset while P1 holds cnt=3 on sf: silent abort, then full latency
    sf_raw = 1'b1;
    step(N + 1);
    check("pending_cnt3", 32'(dbg_state), 32'd1);
    reset = 1'b1;
    step(1);
    reset  = 1'b0;
    exp_gc = 8'd0;
    check("reset_mid_pending", obs(), 32'd0);
    exp_q.push_back(ev(cyc + 16'(N + 2), 4'b1000, 1'b1, 1'b0));
    step(N + 4);
    check("accept_after_reset", obs(), lvl(1'b1, 1'b0, 8'd0));

    step(4);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
